apb_reg_subordinate: RTL and testbench

APB subordinate register bank that sits directly downstream of the APB manager and consumes one selector bit of its bus. Decodes the APB setup/access phases, inserts a parameterised number of wait states, and performs strobe-qualified byte writes into a bank of software-visible registers. Flags error responses on misaligned, out-of-range or read-only-violating accesses. Mixes read/write control registers with read-only status registers sourced from hardware.

---
 rtl/apb_sub_pkg.sv | 23 ++
 rtl/apb_sub_regfile.sv | 57 +++++
 rtl/apb_reg_subordinate.sv | 134 +++++++++++++
 tb/tb_apb_reg_subordinate.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sub_pkg.sv
// Shared types and sizing helpers for the APB register subordinate.
package apb_sub_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int CntWidth = 4;

  // A register index always needs at least one bit, even for a single-register bank.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/apb_sub_regfile.sv
// Register storage with byte-strobe write port and a read mux that
// substitutes hardware status for read-only registers.
module apb_sub_regfile
  import apb_sub_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumRegs = 8,
  parameter logic [NumRegs-1:0] RoMask = '0,
  parameter logic [DataWidth-1:0] ResetVal = '0,
  localparam int IdxW = clog2_min1(NumRegs),
  localparam int StrbW = DataWidth / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [IdxW-1:0]                idx,
  input  logic [DataWidth-1:0]           wdata,
  input  logic [StrbW-1:0]               strb,
  input  logic [NumRegs*DataWidth-1:0]   hw_status,
  output logic [NumRegs*DataWidth-1:0]   regs,
  output logic [DataWidth-1:0]           rd_data
);

  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    if (RoMask[i]) begin : g_ro
      assign regs[i*DataWidth +: DataWidth] = hw_status[i*DataWidth +: DataWidth];
    end else begin : g_rw
      logic [DataWidth-1:0] data_r;
      logic                 unused_hw_s;
      assign unused_hw_s = ^hw_status[i*DataWidth +: DataWidth];

      // Strobe-qualified byte merge into this register.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_r <= ResetVal;
        end else if (wr_en && (idx == IdxW'(i))) begin
          for (int b = 0; b < StrbW; b++) begin
            if (strb[b]) begin
              data_r[b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end

      assign regs[i*DataWidth +: DataWidth] = data_r;
    end
  end

  // Read mux; indices beyond the bank read as zero.
  always_comb begin
    rd_data = {DataWidth{1'b0}};
    for (int i = 0; i < NumRegs; i++) begin
      rd_data = (idx == IdxW'(i)) ? regs[i*DataWidth +: DataWidth] : rd_data;
    end
  end

endmodule

// File: rtl/apb_reg_subordinate.sv
// APB subordinate: setup/access FSM with wait states, address decode and
// error response in front of the register file.
module apb_reg_subordinate
  import apb_sub_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int ProtWidth = 4,
  parameter int NumRegs = 8,
  parameter int WaitStates = 0,
  parameter logic [NumRegs-1:0] RoMask = '0,
  parameter logic [DataWidth-1:0] ResetVal = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sel,
  input  logic                           enable,
  input  logic                           write,
  input  logic [AddrWidth-1:0]           addr,
  input  logic [DataWidth-1:0]           wData,
  input  logic [DataWidth/8-1:0]         strb,
  input  logic [ProtWidth-1:0]           prot,
  output logic                           ready,
  output logic [DataWidth-1:0]           rData,
  output logic                           subError,
  output logic [NumRegs*DataWidth-1:0]   regs,
  input  logic [NumRegs*DataWidth-1:0]   hw_status
);

  localparam int IdxW = clog2_min1(NumRegs);
  localparam int IdxW1 = IdxW + 1;
  localparam int DecW = IdxW + 2;
  localparam int RoExtW = 1 << IdxW;
  localparam logic [IdxW:0] NumRegsW = IdxW1'(NumRegs);
  localparam logic [RoExtW-1:0] RoMaskExt = RoExtW'(RoMask);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(WaitStates);

  apb_state_e             state_r;
  logic [CntWidth-1:0]    cnt_r;
  logic [DecW-1:0]        addr_r;
  logic                   write_r;
  logic [DataWidth-1:0]   wdata_r;
  logic [DataWidth/8-1:0] strb_r;

  logic [IdxW-1:0]        idx_s;
  logic                   done_s;
  logic                   err_s;
  logic                   wr_en_s;
  logic [DataWidth-1:0]   rd_data_s;
  logic                   unused_s;

  // Upper address bits are decoded upstream and protection is not enforced here.
  assign unused_s = ^{prot, addr};

  // Transfer sequencing: setup latches the request, access counts down wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CntWidth{1'b0}};
      addr_r  <= {DecW{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {DataWidth{1'b0}};
      strb_r  <= {(DataWidth/8){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (sel && !enable) begin
            state_r <= ACCESS;
            cnt_r   <= CntLoad;
            addr_r  <= addr[DecW-1:0];
            write_r <= write;
            wdata_r <= wData;
            strb_r  <= strb;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state_r <= IDLE;
          end else if (enable) begin
            if (cnt_r == {CntWidth{1'b0}}) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - CntOne;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign idx_s   = addr_r[2 +: IdxW];
  assign done_s  = (state_r == ACCESS) && sel && enable && (cnt_r == {CntWidth{1'b0}});
  assign wr_en_s = done_s && write_r && !err_s;

  // Misaligned, beyond the bank, or a write to a read-only register.
  always_comb begin
    err_s = (addr_r[1:0] != 2'b00) || ({1'b0, idx_s} >= NumRegsW) ||
            (write_r && RoMaskExt[idx_s]);
  end

  // Response gating: data and error are only driven in the completion cycle.
  always_comb begin
    ready = done_s;
    if (done_s) begin
      subError = err_s;
      rData    = (!write_r && !err_s) ? rd_data_s : {DataWidth{1'b0}};
    end else begin
      subError = 1'b0;
      rData    = {DataWidth{1'b0}};
    end
  end

  apb_sub_regfile #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .RoMask    (RoMask),
    .ResetVal  (ResetVal)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en_s),
    .idx       (idx_s),
    .wdata     (wdata_r),
    .strb      (strb_r),
    .hw_status (hw_status),
    .regs      (regs),
    .rd_data   (rd_data_s)
  );

endmodule

// File: tb/tb_apb_reg_subordinate.sv
// Two subordinates on one APB bus (different wait states, sizes and read-only
// maps), checked every cycle against a transaction-level model.
module tb_apb_reg_subordinate;

  localparam int DW = 32;
  localparam int NR_A = 6;
  localparam int NR_B = 8;
  localparam logic [NR_A-1:0] RO_A = 6'b000100;
  localparam logic [NR_B-1:0] RO_B = 8'b0010_0000;
  localparam logic [31:0] RV_A = 32'h0000_0000;
  localparam logic [31:0] RV_B = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, write;
  logic [1:0]        sel;
  logic [31:0]       addr, wdata;
  logic [3:0]        strb, prot;
  logic [1:0]        ready, serr;
  logic [31:0]       rdata [2];
  logic [NR_A*DW-1:0] regs_a, hw_a;
  logic [NR_B*DW-1:0] regs_b, hw_b;

  apb_reg_subordinate #(.NumRegs(NR_A), .WaitStates(0), .RoMask(RO_A), .ResetVal(RV_A)) dut_a (
    .clk(clk), .reset(reset), .sel(sel[0]), .enable(enable), .write(write), .addr(addr),
    .wData(wdata), .strb(strb), .prot(prot), .ready(ready[0]), .rData(rdata[0]),
    .subError(serr[0]), .regs(regs_a), .hw_status(hw_a));

  apb_reg_subordinate #(.NumRegs(NR_B), .WaitStates(3), .RoMask(RO_B), .ResetVal(RV_B)) dut_b (
    .clk(clk), .reset(reset), .sel(sel[1]), .enable(enable), .write(write), .addr(addr),
    .wData(wdata), .strb(strb), .prot(prot), .ready(ready[1]), .rData(rdata[1]),
    .subError(serr[1]), .regs(regs_b), .hw_status(hw_b));

  // Behavioural model: per-device register contents and configuration.
  int          nr [2] = '{NR_A, NR_B};
  int          ws [2] = '{0, 3};
  int          ro [2] = '{4, 32};
  logic [31:0] rv [2] = '{RV_A, RV_B};
  logic [31:0] mem [2][8];
  logic [31:0] hw  [2][8];

  bit          exp_rdy [2];
  bit          exp_err [2];
  bit          chk_rd  [2];
  logic [31:0] exp_rd  [2];
  bit          chk_en;
  int          cyc, n_tests, n_fail;
  int          rdy_cyc [2];
  int          rdy_prev [2];
  logic [31:0] last_rd [2];
  bit          last_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h7);
  endfunction

  function automatic bit is_ro(input int d, input int ix);
    return ((ro[d] >> ix) & 1) != 0;
  endfunction

  function automatic bit is_err(input int d, input bit wr, input logic [31:0] a);
    return (a % 4 != 0) || (idx_of(a) >= nr[d]) || (wr && is_ro(d, idx_of(a)));
  endfunction

  function automatic logic [31:0] get_reg(input int d, input int r);
    return (d == 0) ? regs_a[r*DW +: DW] : regs_b[r*DW +: DW];
  endfunction

  task automatic pack_hw();
    for (int r = 0; r < NR_A; r++) hw_a[r*DW +: DW] = hw[0][r];
    for (int r = 0; r < NR_B; r++) hw_b[r*DW +: DW] = hw[1][r];
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) for (int r = 0; r < 8; r++) mem[d][r] = rv[d];
  endtask

  task automatic clear_exp();
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0; chk_rd[d] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, outputs and writable register contents.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), 32'(ready[d]), 32'(exp_rdy[d]));
        chk($sformatf("subError%0d", d), 32'(serr[d]), 32'(exp_err[d]));
        if (chk_rd[d]) chk($sformatf("rData%0d", d), rdata[d], exp_rd[d]);
        for (int r = 0; r < nr[d]; r++) begin
          if (!is_ro(d, r)) chk($sformatf("regs%0d_%0d", d, r), get_reg(d, r), mem[d][r]);
        end
        if (ready[d] === 1'b1) begin
          rdy_prev[d] = rdy_cyc[d];
          rdy_cyc[d]  = cyc;
          last_rd[d]  = rdata[d];
          last_err[d] = serr[d];
        end
      end
    end
  end

  // One transfer to device d; stop_at>0 aborts in that access cycle (sel drop or reset).
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int stop_at, input bit use_rst);
    int ix; bit e; logic [31:0] m;
    ix = idx_of(a);
    e  = is_err(d, wr, a);
    clear_exp();
    sel = 2'b00; sel[d] = 1'b1; enable = 1'b0;
    write = wr; addr = a; wdata = wd; strb = st; prot = 4'($urandom);
    tick();
    for (int n = 1; n <= ws[d] + 1; n++) begin
      clear_exp();
      enable = 1'b1; write = 1'($urandom); addr = $urandom; wdata = $urandom; strb = 4'($urandom);
      if (n == stop_at) begin
        if (use_rst) reset = 1'b1;
        else sel[d] = 1'b0;
        tick();
        reset = 1'b0;
        if (use_rst) reset_model();
        return;
      end
      if (n == ws[d] + 1) begin
        exp_rdy[d] = 1'b1;
        exp_err[d] = e;
        chk_rd[d]  = !wr;
        exp_rd[d]  = (e || wr) ? 32'h0 : (is_ro(d, ix) ? hw[d][ix] : mem[d][ix]);
      end
      tick();
    end
    if (wr && !e) begin
      m = 32'h0;
      for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = 8'hFF;
      mem[d][ix] = (mem[d][ix] & ~m) | (wd & m);
    end
  endtask

  // Idle cycles, including stray enables with no preceding setup.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_exp();
      sel = 2'b00; enable = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sel[$urandom_range(0, 1)] = 1'b1;
        enable = 1'b1;
      end
      write = 1'($urandom); addr = $urandom; wdata = $urandom; strb = 4'($urandom);
      tick();
    end
  endtask

  initial begin
    int setup_c, saved, d, stop, usr, low;
    bit wr;
    logic [31:0] a;
    n_tests = 0; n_fail = 0; cyc = 0; chk_en = 1'b0;
    sel = 2'b00; enable = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0; strb = 4'h0; prot = 4'h0;
    for (int i = 0; i < 2; i++) begin
      rdy_cyc[i] = 0; rdy_prev[i] = 0; last_rd[i] = 32'h0; last_err[i] = 1'b0;
      for (int r = 0; r < 8; r++) hw[i][r] = $urandom;
    end
    pack_hw();
    clear_exp();
    reset = 1'b1;
    reset_model();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_b0", get_reg(1, 0), 32'hA5A5_0000);

    // Device A, no wait states.
    xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    chk("wr_reg1", get_reg(0, 1), 32'hDEADBEEF);
    setup_c = cyc + 1;
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0);
    chk("lat_ws0", rdy_cyc[0] - setup_c, 32'd1);
    chk("rd_reg1", last_rd[0], 32'hDEADBEEF);
    chk("rd_reg1_err", 32'(last_err[0]), 32'd0);
    xfer(0, 1'b1, 32'h4, 32'h11223344, 4'h5, 0, 1'b0);
    chk("partial_strb", get_reg(0, 1), 32'hDE22BE44);
    xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    chk("misalign_err", 32'(last_err[0]), 32'd1);
    chk("misalign_keep", get_reg(0, 1), 32'hDE22BE44);
    xfer(0, 1'b1, 32'h8, 32'h12345678, 4'hF, 0, 1'b0);
    chk("ro_write_err", 32'(last_err[0]), 32'd1);
    hw[0][2] = 32'hCAFE0001;
    pack_hw();
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
    chk("ro_read", last_rd[0], 32'hCAFE0001);
    xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0);
    chk("oor_err", 32'(last_err[0]), 32'd1);
    chk("oor_rdata", last_rd[0], 32'h0);

    // Device B, three wait states, back-to-back reads.
    setup_c = cyc + 1;
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
    chk("lat_ws3", rdy_cyc[1] - setup_c, 32'd4);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0);
    chk("b2b_period", rdy_cyc[1] - rdy_prev[1], 32'd5);
    chk("b2b_rdata", last_rd[1], 32'hA5A5_0000);

    // Aborts: dropped select, then reset, both mid-wait.
    saved = rdy_cyc[1];
    xfer(1, 1'b1, 32'h4, 32'h12345678, 4'hF, 2, 1'b0);
    chk("abort_sel_noready", saved, rdy_cyc[1]);
    chk("abort_sel_nowrite", get_reg(1, 1), 32'hA5A5_0000);
    xfer(1, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 0, 1'b0);
    chk("after_abort_wr", get_reg(1, 1), 32'h0BADF00D);
    saved = rdy_cyc[1];
    xfer(1, 1'b1, 32'hC, 32'hFFFFFFFF, 4'hF, 1, 1'b1);
    chk("abort_rst_noready", saved, rdy_cyc[1]);
    chk("abort_rst_b1", get_reg(1, 1), 32'hA5A5_0000);
    chk("abort_rst_a1", get_reg(0, 1), 32'h0000_0000);
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0);
    chk("after_rst_rd", last_rd[1], 32'hA5A5_0000);
    chk("after_rst_err", 32'(last_err[1]), 32'd0);
    idle(3);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom);
      if ($urandom_range(0, 4) == 0) low = $urandom_range(0, 31);
      else low = $urandom_range(0, 7) * 4;
      a = 32'(low);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFE0);
      if ($urandom_range(0, 7) == 0) begin
        hw[d][$urandom_range(0, 7)] = $urandom;
        pack_hw();
      end
      stop = 0;
      usr = 0;
      if (ws[d] > 0 && $urandom_range(0, 9) == 0) begin
        stop = $urandom_range(1, ws[d]);
        usr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      xfer(d, wr, a, $urandom, 4'($urandom), stop, usr[0]);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
